// File: rtl/gate_sweep_engine.sv
// Truth-table sweeper for an N_IN-input gate. Applies every input vector once,
// streams stimulus/result and checks the ones count against the closed-form value.
module gate_sweep_engine #(
    parameter int unsigned N_IN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic            busy,
    output logic [N_IN-1:0] stim_out,
    output logic            y_out,
    output logic            valid_out,
    output logic [N_IN:0]   ones_count,
    output logic            done,
    output logic            pass
);

    localparam int unsigned CW = N_IN + 1;
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [CW-1:0] EXP_ONE  = CW'(1);
    localparam logic [CW-1:0] EXP_FULL = CW'((1 << N_IN) - 1);
    localparam logic [CW-1:0] EXP_HALF = CW'(1 << (N_IN - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [2:0]      mode_q;
    logic            f_c;

    // Gate evaluation; reserved modes produce a constant 0.
    function automatic logic gate_f(input logic [2:0] m, input logic [N_IN-1:0] v);
        case (m)
            3'd0:    gate_f = &v;
            3'd1:    gate_f = |v;
            3'd2:    gate_f = ^v;
            3'd3:    gate_f = ~&v;
            3'd4:    gate_f = ~|v;
            3'd5:    gate_f = ~^v;
            default: gate_f = 1'b0;
        endcase
    endfunction

    // Number of ones each mode must produce over a full sweep.
    function automatic logic [CW-1:0] exp_ones(input logic [2:0] m);
        case (m)
            3'd0:    exp_ones = EXP_ONE;
            3'd1:    exp_ones = EXP_FULL;
            3'd2:    exp_ones = EXP_HALF;
            3'd3:    exp_ones = EXP_FULL;
            3'd4:    exp_ones = EXP_ONE;
            3'd5:    exp_ones = EXP_HALF;
            default: exp_ones = '0;
        endcase
    endfunction

    assign f_c = gate_f(mode_q, idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            mode_q     <= '0;
            busy       <= 1'b0;
            stim_out   <= '0;
            y_out      <= 1'b0;
            valid_out  <= 1'b0;
            ones_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        idx        <= '0;
                        ones_count <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SWEEP;
                    end
                end
                SWEEP: begin
                    stim_out   <= idx;
                    y_out      <= f_c;
                    valid_out  <= 1'b1;
                    ones_count <= ones_count + CW'(f_c);
                    idx        <= idx + N_IN'(1);
                    if (idx == IDX_LAST) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    valid_out <= 1'b0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    pass      <= (mode_q <= 3'd5) && (ones_count == exp_ones(mode_q));
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_engine.sv
// Directed bench for gate_sweep_engine: a 2-input and a 3-input instance
// exercised with hand-computed truth tables and sweep timing.
module tb_gate_sweep_engine;

    logic       clk = 1'b0;
    logic       rst2, start2, rst3, start3;
    logic [2:0] mode2, mode3;

    logic       busy2, y2, valid2, done2, pass2;
    logic [1:0] stim2;
    logic [2:0] ones2;
    logic       busy3, y3, valid3, done3, pass3;
    logic [2:0] stim3;
    logic [3:0] ones3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_sweep_engine #(.N_IN(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .mode(mode2),
        .busy(busy2), .stim_out(stim2), .y_out(y2), .valid_out(valid2),
        .ones_count(ones2), .done(done2), .pass(pass2)
    );

    gate_sweep_engine #(.N_IN(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .mode(mode3),
        .busy(busy3), .stim_out(stim3), .y_out(y3), .valid_out(valid3),
        .ones_count(ones3), .done(done3), .pass(pass3)
    );

    task automatic test_reset();
        rst2 = 1'b1; rst3 = 1'b1; start2 = 1'b1; start3 = 1'b1; mode2 = 3'd0; mode3 = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy2, stim2, y2, valid2, ones2, done2, pass2} !== 10'b0) begin
            failures++;
            $display("FAIL reset_n2 got=%b want=0", {busy2, stim2, y2, valid2, ones2, done2, pass2});
        end
        checks++;
        if ({busy3, stim3, y3, valid3, ones3, done3, pass3} !== 12'b0) begin
            failures++;
            $display("FAIL reset_n3 got=%b want=0", {busy3, stim3, y3, valid3, ones3, done3, pass3});
        end
        rst2 = 1'b0; rst3 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        @(negedge clk);
    endtask

    // AND on 2 inputs: exact cycle-by-cycle timing of the stream and done pulse.
    task automatic test_and2();
        logic [5:0] exp_v;
        start2 = 1'b1; mode2 = 3'd0;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({busy2, valid2, done2, ones2, pass2} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL and2_accept got=%b want=10_0_000_0", {busy2, valid2, done2, ones2, pass2});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_v = {1'b1, 2'(k), (k == 3), 1'b1, 1'b0};
            checks++;
            if ({valid2, stim2, y2, busy2, done2} !== exp_v) begin
                failures++;
                $display("FAIL and2_stream k=%0d got=%b want=%b", k, {valid2, stim2, y2, busy2, done2}, exp_v);
            end
        end
        @(negedge clk);
        checks++;
        if ({done2, busy2, valid2, stim2, y2, ones2, pass2} !== {1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL and2_done got=%b want=100_11_1_001_1", {done2, busy2, valid2, stim2, y2, ones2, pass2});
        end
        @(negedge clk);
        checks++;
        if ({done2, busy2, ones2, pass2} !== {1'b0, 1'b0, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL and2_hold got=%b want=00_001_1", {done2, busy2, ones2, pass2});
        end
    endtask

    // Modes 1..5 on 3 inputs against the truth table and closed-form counts.
    task automatic test_modes3();
        logic [3:0] exp_ones [1:5];
        logic [2:0] v;
        logic       ey;
        exp_ones[1] = 4'd7; exp_ones[2] = 4'd4; exp_ones[3] = 4'd7;
        exp_ones[4] = 4'd1; exp_ones[5] = 4'd4;
        for (int m = 1; m <= 5; m++) begin
            start3 = 1'b1; mode3 = 3'(m);
            @(negedge clk);
            start3 = 1'b0; mode3 = 3'd0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                v = 3'(k);
                case (m)
                    1:       ey = v != 3'd0;
                    2:       ey = v[0] ^ v[1] ^ v[2];
                    3:       ey = v != 3'd7;
                    4:       ey = v == 3'd0;
                    default: ey = ~(v[0] ^ v[1] ^ v[2]);
                endcase
                checks++;
                if ({valid3, stim3, y3} !== {1'b1, v, ey}) begin
                    failures++;
                    $display("FAIL modes3_stream m=%0d k=%0d got=%b want=%b", m, k, {valid3, stim3, y3}, {1'b1, v, ey});
                end
            end
            @(negedge clk);
            checks++;
            if ({done3, busy3, ones3, pass3} !== {1'b1, 1'b0, exp_ones[m], 1'b1}) begin
                failures++;
                $display("FAIL modes3_done m=%0d got=%b want=%b", m, {done3, busy3, ones3, pass3}, {1'b1, 1'b0, exp_ones[m], 1'b1});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reserved2();
        start2 = 1'b1; mode2 = 3'd6;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({valid2, y2} !== 2'b10) begin
                failures++;
                $display("FAIL reserved_y k=%0d got=%b want=10", k, {valid2, y2});
            end
        end
        @(negedge clk);
        checks++;
        if ({done2, busy2, ones2, pass2} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reserved_done got=%b want=10_000_0", {done2, busy2, ones2, pass2});
        end
        @(negedge clk);
    endtask

    // start and mode wiggled mid-sweep must not affect the latched OR sweep.
    task automatic test_disturb();
        int dones = 0;
        start2 = 1'b1; mode2 = 3'd1;
        @(negedge clk);
        start2 = 1'b0; mode2 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dones += int'(done2);
            if (k == 1) begin start2 = 1'b1; mode2 = 3'd4; end
            if (k == 2) start2 = 1'b0;
            checks++;
            if ({valid2, stim2, y2} !== {1'b1, 2'(k), (k != 0)}) begin
                failures++;
                $display("FAIL disturb_stream k=%0d got=%b want=%b", k, {valid2, stim2, y2}, {1'b1, 2'(k), (k != 0)});
            end
        end
        @(negedge clk);
        dones += int'(done2);
        checks++;
        if ({done2, ones2, pass2} !== {1'b1, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL disturb_done got=%b want=1_011_1", {done2, ones2, pass2});
        end
        repeat (4) begin
            @(negedge clk);
            dones += int'(done2);
        end
        checks++;
        if (dones !== 1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL disturb_single dones=%0d busy=%b want dones=1 busy=0", dones, busy2);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        start2 = 1'b1; mode2 = 3'd0;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        checks++;
        if ({busy2, stim2, y2, valid2, ones2, done2, pass2} !== 10'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b want=0", {busy2, stim2, y2, valid2, ones2, done2, pass2});
        end
        repeat (6) begin
            @(negedge clk);
            dones += int'(done2) + int'(busy2) + int'(valid2);
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet activity=%0d want=0", dones);
        end
        start2 = 1'b1; mode2 = 3'd3;
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({valid2, stim2, y2} !== {1'b1, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_nand_last got=%b want=1_11_0", {valid2, stim2, y2});
        end
        @(negedge clk);
        checks++;
        if ({done2, ones2, pass2} !== {1'b1, 3'd3, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_rerun got=%b want=1_011_1", {done2, ones2, pass2});
        end
        @(negedge clk);
    endtask

    // start held high: second XOR sweep begins the edge after done.
    task automatic test_back_to_back();
        start2 = 1'b1; mode2 = 3'd2;
        @(negedge clk);
        repeat (4) @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done2, busy2, ones2, pass2} !== {1'b1, 1'b0, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first got=%b want=10_010_1", {done2, busy2, ones2, pass2});
        end
        @(negedge clk);
        checks++;
        if ({done2, busy2, valid2, ones2, pass2} !== {1'b0, 1'b1, 1'b0, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_restart got=%b want=010_000_0", {done2, busy2, valid2, ones2, pass2});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({valid2, stim2, y2} !== {1'b1, 2'(k), (k == 1 || k == 2)}) begin
                failures++;
                $display("FAIL b2b_stream k=%0d got=%b want=%b", k, {valid2, stim2, y2}, {1'b1, 2'(k), (k == 1 || k == 2)});
            end
        end
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({done2, busy2, ones2, pass2} !== {1'b1, 1'b0, 3'd2, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second got=%b want=10_010_1", {done2, busy2, ones2, pass2});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_stop got=%b want=00", {busy2, done2});
        end
    endtask

    initial begin
        test_reset();
        test_and2();
        test_modes3();
        test_reserved2();
        test_disturb();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sweep_engine.md
Name: gate_sweep_engine

Overview:
- Parametrised, self-checking successor to the 2-input AND gate bench, built as synthesizable RTL.
- Latches a gate mode (AND/OR/XOR/NAND/NOR/XNOR) for an N_IN-input gate on start.
- Sweeps all 2^N_IN input combinations, one per clock, and streams stimulus and registered result.
- Counts result ones and flags pass when the count matches the closed-form expected value for the mode. Used as a built-in truth-table checker alongside the gate library.

Parameters:
- N_IN, 2, number of gate inputs; legal range 2..8; sweep length is 2^N_IN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  sweep request; sampled only in IDLE
- mode  in  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR 6,7=reserved; latched at start acceptance
- busy  out  1  high from start acceptance until the done cycle
- stim_out  out  N_IN  current input vector
- y_out  out  1  gate result for stim_out
- valid_out  out  1  stim_out/y_out valid this cycle
- ones_count  out  N_IN+1  running count of y_out==1 in the current sweep
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  result of final check; held until the next start is accepted

Behaviour:
- Reset:
  - At any rising edge with rst=1, state<=IDLE and all outputs<=0 (busy, stim_out, y_out, valid_out, ones_count, done, pass).
  - Reset applies mid-sweep with no completion and no done pulse.
  - rst overrides start at the same edge.
- States: IDLE, SWEEP, FIN. Internal idx is N_IN bits; mode_q is 3 bits.
- IDLE:
  - If start=1 at edge E0: mode_q<=mode, idx<=0, ones_count<=0, pass<=0, busy<=1, state<=SWEEP.
  - Otherwise all outputs hold their values, so pass and ones_count persist after a sweep.
- SWEEP, at each edge:
  - stim_out<=idx
  - y_out<=f(mode_q, idx)
  - valid_out<=1
  - ones_count<=ones_count+f(mode_q, idx)
  - idx<=idx+1 (wraps to 0 after the last value)
  - If idx==2^N_IN-1, state<=FIN.
- Gate function f:
  - AND = &idx, OR = |idx, XOR = ^idx; NAND, NOR and XNOR are their complements.
  - Reserved modes give f=0.
- FIN, at one edge:
  - valid_out<=0, done<=1, busy<=0, state<=IDLE.
  - pass<=(mode_q<=5) && (ones_count==EXP(mode_q)).
  - stim_out and y_out hold their last values.
- done returns to 0 at the following edge.
- EXP values: AND=1; OR=2^N_IN-1; XOR=2^(N_IN-1); NAND=2^N_IN-1; NOR=1; XNOR=2^(N_IN-1). ones_count width N_IN+1 holds 2^N_IN without overflow.
- Timing, relative to the accepting edge E0:
  - valid_out is high after edges E0+1 through E0+2^N_IN; stim_out=k after edge E0+1+k.
  - done is high for exactly the cycle after edge E0+2^N_IN+1.
  - busy is high after E0 through edge E0+2^N_IN; it falls at the same edge where done rises.
- start while busy (SWEEP or FIN) is ignored, with no queuing.
- If start is held high, a new sweep is accepted at the first edge after done; pass and ones_count clear at that edge.
- Changes on mode during a sweep have no effect.

Test Plan:
- N_IN=2, mode=0, pulse start:
  - stim_out 0,1,2,3 on consecutive cycles, y_out 0,0,0,1, valid_out high exactly 4 cycles.
  - done pulses 5 cycles after the start edge; ones_count=1, pass=1.
- N_IN=3, modes 1..5, one sweep each:
  - ones_count 7,4,7,1,4 respectively; pass=1 for each.
  - y_out per vector matches the truth table (e.g. XOR stim=5 -> 0, stim=7 -> 1).
- N_IN=2, mode=6: y_out always 0, ones_count=0, done pulses, pass=0, busy drops.
- Mid-sweep disturbances:
  - start pulse during SWEEP -> ignored, exactly one sweep and one done.
  - mode toggled during SWEEP -> results follow the latched mode.
- Reset mid-sweep: rst=1 at the 2nd SWEEP cycle -> next cycle all outputs 0, no done pulse; a following start runs a clean full sweep with pass=1.
- Back-to-back runs:
  - start held high through two sweeps -> second sweep begins the cycle after done.
  - ones_count restarts from 0; pass cleared at the restart edge and re-asserted at the second done.
